instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_pkg.sv | 24 ++
 rtl/instruction_fetch_if.sv | 27 ++
 rtl/instruction_fetch_instr_mem.sv | 24 ++
 rtl/instruction_fetch.sv | 88 ++++++++
 tb/tb_instruction_fetch.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared CPU definitions for the fetch stage: widths, halt opcode, FSM encoding
// and the halt-detection helper.
package instruction_fetch_pkg;

    localparam int PC_W       = 3;
    localparam int IMEM_DEPTH = 8;
    localparam int INSTR_W    = 16;
    localparam int OPCODE_W   = 4;
    localparam int COUNT_W    = 8;

    localparam logic [OPCODE_W-1:0] HALT_OPCODE_DEFAULT = 4'hF;
    localparam logic [COUNT_W-1:0]  COUNT_MAX           = 8'd255;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_e;

    function automatic logic is_halt(input logic [INSTR_W-1:0]  instr,
                                     input logic [OPCODE_W-1:0] halt_op);
        return (instr[INSTR_W-1 -: OPCODE_W] == halt_op);
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: control inputs, instruction-memory load port and IF/ID outputs.
interface instruction_fetch_if;
    import instruction_fetch_pkg::*;

    logic                stall;
    logic                branch_taken;
    logic [PC_W-1:0]     branch_target;
    logic                load_en;
    logic [PC_W-1:0]     load_addr;
    logic [INSTR_W-1:0]  load_data;
    logic [INSTR_W-1:0]  instruction_out;
    logic [PC_W-1:0]     pc_out;
    logic                valid_out;
    logic                halted;
    logic [COUNT_W-1:0]  fetch_count;

    modport master (
        output stall, branch_taken, branch_target, load_en, load_addr, load_data,
        input  instruction_out, pc_out, valid_out, halted, fetch_count
    );

    modport slave (
        input  stall, branch_taken, branch_target, load_en, load_addr, load_data,
        output instruction_out, pc_out, valid_out, halted, fetch_count
    );

endinterface

// File: rtl/instruction_fetch_instr_mem.sv
// 8x16 instruction memory: synchronous write, asynchronous read, contents never reset.
module instr_mem
    import instruction_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic [PC_W-1:0]    waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [PC_W-1:0]    raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem_r [IMEM_DEPTH];

    // Write port; a read of the same address sees the new word only after this edge
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, RUN/HALTED FSM and saturating fetch counter around instr_mem.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [OPCODE_W-1:0] HALT_OPCODE = HALT_OPCODE_DEFAULT
)(
    input  logic                clk,
    input  logic                reset,
    instruction_fetch_if.slave  bus
);

    fetch_state_e        state_r;
    fetch_state_e        state_next_s;
    logic [PC_W-1:0]     pc_r;
    logic [PC_W-1:0]     pc_next_s;
    logic [COUNT_W-1:0]  count_r;
    logic [COUNT_W-1:0]  count_next_s;
    logic [INSTR_W-1:0]  instr_s;
    logic                mem_we_s;

    // Reset outranks loads, so a program cannot be corrupted on the reset edge
    assign mem_we_s = bus.load_en & ~reset;

    instr_mem u_instr_mem (
        .clk   (clk),
        .we    (mem_we_s),
        .waddr (bus.load_addr),
        .wdata (bus.load_data),
        .raddr (pc_r),
        .rdata (instr_s)
    );

    // Next-state logic: branch beats stall and halt in every state
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        count_next_s = count_r;
        case (state_r)
            ST_RUN: begin
                if (bus.branch_taken) begin
                    state_next_s = ST_RUN;
                    pc_next_s    = bus.branch_target;
                end else if (!bus.stall) begin
                    count_next_s = (count_r == COUNT_MAX) ? count_r : (count_r + 8'd1);
                    if (is_halt(instr_s, HALT_OPCODE)) begin
                        state_next_s = ST_HALTED;
                    end else begin
                        pc_next_s = pc_r + 3'd1;
                    end
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (bus.branch_taken) begin
                    state_next_s = ST_RUN;
                    pc_next_s    = bus.branch_target;
                end else begin
                    state_next_s = ST_HALTED;
                end
            end
            default: begin
                state_next_s = ST_RUN;
                pc_next_s    = {PC_W{1'b0}};
            end
        endcase
    end

    // State, PC and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_RUN;
            pc_r    <= {PC_W{1'b0}};
            count_r <= {COUNT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            pc_r    <= pc_next_s;
            count_r <= count_next_s;
        end
    end

    assign bus.instruction_out = instr_s;
    assign bus.pc_out          = pc_r;
    assign bus.valid_out       = (state_r == ST_RUN);
    assign bus.halted          = (state_r == ST_HALTED);
    assign bus.fetch_count     = count_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: per-cycle scoreboard plus scenario checks.
module tb_instruction_fetch;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    instruction_fetch_if bus();

    instruction_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  pc;
        logic [15:0] instr;
        logic        instr_known;
        logic        valid;
        logic        halted;
        logic [7:0]  count;
    } exp_t;

    exp_t sb_q[$];

    // Reference model of the fetch stage
    logic [15:0] m_mem   [8];
    logic        m_known [8] = '{default: 1'b0};
    logic [2:0]  m_pc    = 3'd0;
    logic        m_run   = 1'b1;
    logic [7:0]  m_count = 8'd0;

    task automatic idle();
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 3'd0;
        bus.load_en       = 1'b0;
        bus.load_addr     = 3'd0;
        bus.load_data     = 16'h0000;
    endtask

    // Advance one clock: predict, push, clock, pop and compare
    task automatic cycle();
        exp_t        e;
        exp_t        got;
        logic [15:0] cur_word;
        cur_word = m_mem[m_pc];
        if (reset) begin
            m_pc    = 3'd0;
            m_run   = 1'b1;
            m_count = 8'd0;
        end else begin
            if (bus.branch_taken) begin
                m_pc  = bus.branch_target;
                m_run = 1'b1;
            end else if (m_run && !bus.stall) begin
                if (m_count != 8'd255) m_count = m_count + 8'd1;
                if (cur_word[15:12] == 4'hF) m_run = 1'b0;
                else m_pc = m_pc + 3'd1;
            end
            if (bus.load_en) begin
                m_mem[bus.load_addr]   = bus.load_data;
                m_known[bus.load_addr] = 1'b1;
            end
        end
        e.pc          = m_pc;
        e.instr       = m_mem[m_pc];
        e.instr_known = m_known[m_pc];
        e.valid       = m_run;
        e.halted      = ~m_run;
        e.count       = m_count;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        checks++;
        if (bus.pc_out !== got.pc) begin
            errors++;
            $display("FAIL sb_pc: got %0d expected %0d at %0t", bus.pc_out, got.pc, $time);
        end
        checks++;
        if (bus.valid_out !== got.valid || bus.halted !== got.halted) begin
            errors++;
            $display("FAIL sb_state: got valid=%b halted=%b expected valid=%b halted=%b at %0t",
                     bus.valid_out, bus.halted, got.valid, got.halted, $time);
        end
        checks++;
        if (bus.fetch_count !== got.count) begin
            errors++;
            $display("FAIL sb_count: got %0d expected %0d at %0t", bus.fetch_count, got.count, $time);
        end
        if (got.instr_known) begin
            checks++;
            if (bus.instruction_out !== got.instr) begin
                errors++;
                $display("FAIL sb_instr: got %h expected %h at %0t", bus.instruction_out, got.instr, $time);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        do_reset();
        checks++;
        if (bus.pc_out !== 3'd0 || bus.valid_out !== 1'b1 || bus.halted !== 1'b0 || bus.fetch_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: got pc=%0d valid=%b halted=%b count=%0d expected 0 1 0 0",
                     bus.pc_out, bus.valid_out, bus.halted, bus.fetch_count);
        end
    endtask

    task automatic test_load_and_run();
        bus.stall   = 1'b1;
        bus.load_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.load_addr = i[2:0];
            bus.load_data = (i == 7) ? 16'hF000 : (16'h1001 + 16'(i));
            cycle();
        end
        idle();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bus.pc_out !== i[2:0] || bus.instruction_out !== ((i == 7) ? 16'hF000 : (16'h1001 + 16'(i)))) begin
                errors++;
                $display("FAIL run_seq: got pc=%0d instr=%h at step %0d", bus.pc_out, bus.instruction_out, i);
            end
            cycle();
        end
        checks++;
        if (bus.halted !== 1'b1 || bus.fetch_count !== 8'd8 || bus.pc_out !== 3'd7) begin
            errors++;
            $display("FAIL run_halt: got halted=%b count=%0d pc=%0d expected 1 8 7",
                     bus.halted, bus.fetch_count, bus.pc_out);
        end
        cycle();
        checks++;
        if (bus.pc_out !== 3'd7 || bus.halted !== 1'b1) begin
            errors++;
            $display("FAIL run_hold: got pc=%0d halted=%b expected 7 1", bus.pc_out, bus.halted);
        end
    endtask

    task automatic test_stall();
        idle();
        do_reset();
        cycle();
        cycle();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (bus.pc_out !== 3'd2 || bus.instruction_out !== 16'h1003 || bus.fetch_count !== 8'd2) begin
                errors++;
                $display("FAIL stall_hold: got pc=%0d instr=%h count=%0d expected 2 1003 2",
                         bus.pc_out, bus.instruction_out, bus.fetch_count);
            end
        end
        bus.stall = 1'b0;
        cycle();
        checks++;
        if (bus.pc_out !== 3'd3 || bus.fetch_count !== 8'd3) begin
            errors++;
            $display("FAIL stall_resume: got pc=%0d count=%0d expected 3 3", bus.pc_out, bus.fetch_count);
        end
    endtask

    task automatic test_branch_over_stall();
        idle();
        do_reset();
        cycle();
        bus.stall         = 1'b1;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 3'd5;
        cycle();
        idle();
        checks++;
        if (bus.pc_out !== 3'd5 || bus.fetch_count !== 8'd1 || bus.valid_out !== 1'b1) begin
            errors++;
            $display("FAIL branch_stall: got pc=%0d count=%0d valid=%b expected 5 1 1",
                     bus.pc_out, bus.fetch_count, bus.valid_out);
        end
    endtask

    task automatic test_halted();
        idle();
        do_reset();
        for (int i = 0; i < 8; i++) cycle();
        for (int i = 0; i < 4; i++) begin
            bus.stall = i[0];
            cycle();
            checks++;
            if (bus.pc_out !== 3'd7 || bus.halted !== 1'b1 || bus.valid_out !== 1'b0 || bus.fetch_count !== 8'd8) begin
                errors++;
                $display("FAIL halted_stall: got pc=%0d halted=%b valid=%b count=%0d expected 7 1 0 8",
                         bus.pc_out, bus.halted, bus.valid_out, bus.fetch_count);
            end
        end
        idle();
        bus.branch_taken  = 1'b1;
        bus.branch_target = 3'd0;
        cycle();
        idle();
        checks++;
        if (bus.pc_out !== 3'd0 || bus.valid_out !== 1'b1 || bus.halted !== 1'b0 || bus.fetch_count !== 8'd8) begin
            errors++;
            $display("FAIL halted_branch: got pc=%0d valid=%b halted=%b count=%0d expected 0 1 0 8",
                     bus.pc_out, bus.valid_out, bus.halted, bus.fetch_count);
        end
    endtask

    task automatic test_saturate();
        logic [2:0] prev_pc;
        logic       saw_wrap;
        idle();
        bus.stall     = 1'b1;
        bus.load_en   = 1'b1;
        bus.load_addr = 3'd7;
        bus.load_data = 16'h1008;
        cycle();
        idle();
        do_reset();
        saw_wrap = 1'b0;
        for (int i = 0; i < 300; i++) begin
            prev_pc = bus.pc_out;
            cycle();
            if (prev_pc == 3'd7 && bus.pc_out == 3'd0) saw_wrap = 1'b1;
        end
        checks++;
        if (saw_wrap !== 1'b1) begin
            errors++;
            $display("FAIL sat_wrap: got wrap=%b expected 1", saw_wrap);
        end
        checks++;
        if (bus.fetch_count !== 8'd255 || bus.pc_out !== 3'd4) begin
            errors++;
            $display("FAIL sat_count: got count=%0d pc=%0d expected 255 4", bus.fetch_count, bus.pc_out);
        end
    endtask

    task automatic test_write_current_and_reset();
        idle();
        do_reset();
        bus.stall     = 1'b1;
        bus.load_en   = 1'b1;
        bus.load_addr = 3'd0;
        bus.load_data = 16'hABCD;
        #1;
        checks++;
        if (bus.instruction_out !== 16'h1001) begin
            errors++;
            $display("FAIL wr_old: got %h expected 1001", bus.instruction_out);
        end
        cycle();
        checks++;
        if (bus.instruction_out !== 16'hABCD) begin
            errors++;
            $display("FAIL wr_new: got %h expected abcd", bus.instruction_out);
        end
        bus.load_addr = 3'd7;
        bus.load_data = 16'hF000;
        cycle();
        idle();
        bus.branch_taken  = 1'b1;
        bus.branch_target = 3'd7;
        cycle();
        idle();
        cycle();
        checks++;
        if (bus.halted !== 1'b1) begin
            errors++;
            $display("FAIL wr_halt: got halted=%b expected 1", bus.halted);
        end
        reset             = 1'b1;
        bus.stall         = 1'b1;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 3'd5;
        bus.load_en       = 1'b1;
        bus.load_addr     = 3'd3;
        bus.load_data     = 16'hDEAD;
        cycle();
        reset = 1'b0;
        idle();
        checks++;
        if (bus.pc_out !== 3'd0 || bus.valid_out !== 1'b1 || bus.halted !== 1'b0 ||
            bus.fetch_count !== 8'd0 || bus.instruction_out !== 16'hABCD) begin
            errors++;
            $display("FAIL rst_halted: got pc=%0d valid=%b halted=%b count=%0d instr=%h expected 0 1 0 0 abcd",
                     bus.pc_out, bus.valid_out, bus.halted, bus.fetch_count, bus.instruction_out);
        end
        bus.branch_taken  = 1'b1;
        bus.branch_target = 3'd3;
        cycle();
        idle();
        checks++;
        if (bus.instruction_out !== 16'h1004) begin
            errors++;
            $display("FAIL rst_preserve: got %h expected 1004", bus.instruction_out);
        end
    endtask

    initial begin
        idle();
        @(posedge clk);
        #1;
        test_reset();
        test_load_and_run();
        test_stall();
        test_branch_over_stall();
        test_halted();
        test_saturate();
        test_write_current_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
